// File: rtl/player_move_controller.sv
// Snake-and-ladder move engine: walks the current player's token one square per step tick, applies the jump table, detects the winner.
// Optional macro SIX_EXTRA_TURN_EN: a roll of 6 keeps the same player on turn.
module player_move_controller #(
  parameter int NUM_PLAYERS = 2,
  parameter int BOARD_SIZE  = 100,
  parameter int STEP_DELAY  = 25_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dice_valid,
  input  logic [3:0]               dice_value,
  output logic                     busy,
  output logic [1:0]               current_player,
  output logic [7*NUM_PLAYERS-1:0] pos_bus,
  output logic                     move_done,
  output logic [3:0]               winner,
  output logic [2:0]               fsm_state
);

  typedef enum logic [2:0] {IDLE, CHECK, STEP, WAIT, JUMP, NEXT, WON} state_t;

  // STEP itself is the first cycle of every square, so WAIT covers the remaining STEP_DELAY-1.
  localparam int CW = (STEP_DELAY > 2) ? $clog2(STEP_DELAY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((STEP_DELAY >= 2) ? STEP_DELAY - 2 : 0);

  state_t        state;
  logic [2:0]    steps;
  logic [2:0]    roll;
  logic [CW-1:0] delay;
  logic [6:0]    cur_pos;
  logic [7:0]    target;
  logic [6:0]    dest;
  logic [1:0]    next_player;

  function automatic logic [6:0] jump_to(input logic [6:0] p);
    case (p)
      7'd4:    jump_to = 7'd14;
      7'd9:    jump_to = 7'd31;
      7'd21:   jump_to = 7'd42;
      7'd28:   jump_to = 7'd84;
      7'd51:   jump_to = 7'd67;
      7'd72:   jump_to = 7'd91;
      7'd80:   jump_to = 7'd99;
      7'd17:   jump_to = 7'd7;
      7'd54:   jump_to = 7'd34;
      7'd62:   jump_to = 7'd19;
      7'd64:   jump_to = 7'd60;
      7'd87:   jump_to = 7'd36;
      7'd93:   jump_to = 7'd73;
      7'd95:   jump_to = 7'd75;
      7'd98:   jump_to = 7'd79;
      default: jump_to = p;
    endcase
  endfunction

  assign cur_pos     = pos_bus[7*current_player +: 7];
  assign target      = {1'b0, cur_pos} + {5'b0, steps};
  assign dest        = jump_to(cur_pos);
  assign next_player = (current_player == 2'(NUM_PLAYERS - 1)) ? 2'd0 : current_player + 2'd1;
  assign busy        = (state != IDLE) && (state != WON);
  assign fsm_state   = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pos_bus        <= '0;
      current_player <= 2'd0;
      winner         <= 4'd0;
      move_done      <= 1'b0;
      steps          <= 3'd0;
      roll           <= 3'd0;
      delay          <= '0;
    end else begin
      move_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dice_valid && dice_value >= 4'd1 && dice_value <= 4'd6) begin
            steps <= dice_value[2:0];
            roll  <= dice_value[2:0];
            state <= CHECK;
          end
        end
        CHECK: begin
          if (target > 8'(BOARD_SIZE)) begin
            move_done <= 1'b1;
            state     <= NEXT;
          end else begin
            state <= STEP;
          end
        end
        STEP: begin
          pos_bus[7*current_player +: 7] <= cur_pos + 7'd1;
          steps <= steps - 3'd1;
          delay <= WAIT_LOAD;
          if (STEP_DELAY > 1)      state <= WAIT;
          else if (steps != 3'd1) state <= STEP;
          else                    state <= JUMP;
        end
        WAIT: begin
          if (delay == '0) state <= (steps != 3'd0) ? STEP : JUMP;
          else             delay <= delay - CW'(1);
        end
        JUMP: begin
          pos_bus[7*current_player +: 7] <= dest;
          move_done <= 1'b1;
          if (dest == 7'(BOARD_SIZE)) begin
            winner <= {2'b00, current_player} + 4'd1;
            state  <= WON;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
`ifdef SIX_EXTRA_TURN_EN
          if (roll != 3'd6) current_player <= next_player;
`else
          current_player <= next_player;
`endif
          state <= IDLE;
        end
        WON: state <= WON;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
